// File: rtl/functional_memory_pkg.sv
// ----------------------------------------------------------------------------
// functional_memory_pkg
//   Shared types and constants for the functional_memory AXI4-Lite master:
//   the master FSM state encoding, AXI response codes, the default AxPROT
//   value, and a helper that classifies a response code as an error.
// ----------------------------------------------------------------------------
package functional_memory_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD    = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are the two error codes; OKAY/EXOKAY are success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/functional_memory_axi_master.sv
// ----------------------------------------------------------------------------
// functional_memory_axi_master
//   Converts a valid/ready word request port into single AXI4-Lite read or
//   write transactions, one outstanding at a time, and returns read data and
//   an error flag on a valid/ready response port. Every output is a flop.
//
// Ports
//   ACLK, ARESET        clock and synchronous active-high reset
//   req_*               request in (valid/ready, we, addr, wdata, wstrb)
//   rsp_*               response out (valid/ready, rdata, err)
//   M_AXI_AW*/W*/B*     AXI4-Lite write address / data / response channels
//   M_AXI_AR*/R*        AXI4-Lite read address / data channels
// ----------------------------------------------------------------------------
module functional_memory_axi_master
  import functional_memory_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  // AXI write data
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  // AXI write response
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  // AXI read data
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  // Masking (rather than slicing) keeps every request address bit in use
  // while forcing the byte-offset bits to zero.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ADDR_LSB) - ADDR_WIDTH'(1));

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                  req_ready_q, req_ready_d;
  logic                  awvalid_q,   awvalid_d;
  logic                  wvalid_q,    wvalid_d;
  logic                  bready_q,    bready_d;
  logic                  arvalid_q,   arvalid_d;
  logic                  rready_q,    rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  // NOTE: every variable gets a default before the case statement so no
  // path through this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr & ALIGN_MASK;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        // AW and W complete independently; a dropped VALID is the done flag.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WRESP;
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          rsp_err_d   = resp_is_err(M_AXI_BRESP);
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD: begin
        if (M_AXI_ARREADY) state_d = RDATA;
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          rsp_err_d   = resp_is_err(M_AXI_RRESP);
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Single-bit controls are registered decodes of the next state, so each
    // rises on entry to its state and falls on exit.
    req_ready_d = (state_d == IDLE);
    bready_d    = (state_d == WRESP);
    arvalid_d   = (state_d == RD);
    rready_d    = (state_d == RDATA);
    rsp_valid_d = (state_d == RSP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

  // One captured address serves both AW and AR; only one is ever valid.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_functional_memory_axi_master.sv
// ----------------------------------------------------------------------------
// tb_functional_memory_axi_master
//   Drives the request port, emulates a word-addressed AXI4-Lite memory slave
//   with programmable ready/response delays (SLVERR at 0x1000..0x1FFF, DECERR
//   from 0x2000), and compares every response against a word-array model of
//   the memory. A monitor flags VALID drops without handshake, unstable
//   payloads, unaligned addresses and non-zero AxPROT.
// ----------------------------------------------------------------------------
module tb_functional_memory_axi_master;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  functional_memory_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESET(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------------------------------------------------------- slave
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] smem [0:1023] = '{default: '0};
  logic proto_err = 1'b0;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0, rsp_pend = 1'b0;
  logic [31:0] aw_hold = '0, w_hold = '0, ar_hold = '0, rsp_hold = '0;
  logic rsp_err_hold = 1'b0;

  assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign wready  = wvalid  && !w_got  && (w_cnt  >= w_delay);
  assign arready = arvalid && !ar_got && (ar_cnt >= ar_delay);

  function automatic logic [1:0] s_resp(input logic [31:0] a);
    if (a >= 32'h2000) return 2'b11;
    if (a >= 32'h1000) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; s_awaddr <= awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1;
        if (awaddr[1:0] != 2'b00 || awprot != 3'b000) proto_err <= 1'b1;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;

      if (wvalid && wready) begin
        w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; w_cnt <= 0; w_hs <= w_hs + 1;
      end else if (wvalid) w_cnt <= w_cnt + 1;

      if (bvalid && bready) bvalid <= 1'b0;
      else if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= b_delay) begin
          bresp <= s_resp(s_awaddr);
          if (s_resp(s_awaddr) == 2'b00)
            for (int i = 0; i < 4; i++)
              if (s_wstrb[i]) smem[s_awaddr[11:2]][8*i +: 8] <= s_wdata[8*i +: 8];
          bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end

      if (arvalid && arready) begin
        ar_got <= 1'b1; s_araddr <= araddr; ar_cnt <= 0; ar_hs <= ar_hs + 1;
        if (araddr[1:0] != 2'b00 || arprot != 3'b000) proto_err <= 1'b1;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;

      if (rvalid && rready) rvalid <= 1'b0;
      else if (ar_got && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rresp  <= s_resp(s_araddr);
          rdata  <= (s_resp(s_araddr) == 2'b00) ? smem[s_araddr[11:2]] : 32'h0;
          rvalid <= 1'b1; ar_got <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end

      // A VALID that waited last edge must still be up with the same payload.
      if (aw_pend && (!awvalid || awaddr != aw_hold)) proto_err <= 1'b1;
      if (w_pend  && (!wvalid  || wdata  != w_hold))  proto_err <= 1'b1;
      if (ar_pend && (!arvalid || araddr != ar_hold)) proto_err <= 1'b1;
      if (rsp_pend && (!rsp_valid || rsp_rdata != rsp_hold || rsp_err != rsp_err_hold))
        proto_err <= 1'b1;
    end
    aw_pend  <= !areset && awvalid && !awready;
    w_pend   <= !areset && wvalid && !wready;
    ar_pend  <= !areset && arvalid && !arready;
    rsp_pend <= !areset && rsp_valid && !rsp_ready;
    aw_hold <= awaddr; w_hold <= wdata; ar_hold <= araddr;
    rsp_hold <= rsp_rdata; rsp_err_hold <= rsp_err;
  end

  // ------------------------------------------------------- reference model
  logic [31:0] ref_mem [0:1023];

  task automatic model_apply(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] ws, output logic [31:0] exp_rd,
                             output logic exp_err);
    int idx;
    idx     = int'(addr[11:2]);
    exp_err = (addr >= 32'h1000);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (ws[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        exp_rd = ref_mem[idx];
      end
    end
  endtask

  // --------------------------------------------------------------- checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents a request and returns once it has been accepted.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    n = 0;
    while (!req_ready && n < BUDGET) begin @(negedge clk); n++; end
    check("accept_wait", 64'(req_ready), 64'd1);
    if (req_ready) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int rsp_wait, output logic [31:0] rd, output logic err);
    int n;
    n = 0;
    while (!rsp_valid && n < BUDGET) begin @(negedge clk); n++; end
    check("rsp_wait", 64'(rsp_valid), 64'd1);
    repeat (rsp_wait) @(negedge clk);
    rd = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int rsp_wait,
                        output logic [31:0] rd, output logic err);
    send_req(we, addr, wd, ws);
    get_rsp(rsp_wait, rd, err);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [19];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          aw0, w0, ar0;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    vecs[0]  = '{1'b1, 32'h0000, 32'h0000_0001, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0004, 32'h0000_0002, 4'hF, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0008, 32'h0000_0003, 4'hF, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h000C, 32'h0000_0004, 4'hF, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000, 32'h0,         4'h0, 32'h0000_0001, 1'b0};
    vecs[5]  = '{1'b0, 32'h0004, 32'h0,         4'h0, 32'h0000_0002, 1'b0};
    vecs[6]  = '{1'b0, 32'h0008, 32'h0,         4'h0, 32'h0000_0003, 1'b0};
    vecs[7]  = '{1'b0, 32'h000C, 32'h0,         4'h0, 32'h0000_0004, 1'b0};
    vecs[8]  = '{1'b1, 32'h0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0010, 32'hAABB_CCDD, 4'h3, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h0010, 32'h0,         4'h0, 32'h1122_CCDD, 1'b0};
    vecs[11] = '{1'b0, 32'h1000, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h0004, 32'h0,         4'h0, 32'h0000_0002, 1'b0};
    vecs[13] = '{1'b0, 32'h000E, 32'h0,         4'h0, 32'h0000_0004, 1'b0};
    vecs[14] = '{1'b1, 32'h2000, 32'h0000_0055, 4'hF, 32'h0, 1'b1};
    vecs[15] = '{1'b1, 32'h1004, 32'h7777_7777, 4'hF, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h2004, 32'h0,         4'h0, 32'h0, 1'b1};
    vecs[17] = '{1'b1, 32'h0014, 32'hFFFF_FFFF, 4'h8, 32'h0, 1'b0};
    vecs[18] = '{1'b0, 32'h0014, 32'h0,         4'h0, 32'hFF00_0000, 1'b0};

    // Reset behaviour.
    areset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_valids", {59'd0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
    check("reset_rsp", {31'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    areset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Directed vectors.
    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, rd, er);
      model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, m_rd, m_er);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
    end

    // AWREADY well ahead of WREADY, then the reverse.
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 0 : 3;
      w_delay  = (k == 0) ? 3 : 0;
      aw0 = aw_hs; w0 = w_hs;
      do_req(1'b1, 32'h18 + 32'(4 * k), 32'hCAFE_0000 + 32'(k), 4'hF, 0, rd, er);
      model_apply(1'b1, 32'h18 + 32'(4 * k), 32'hCAFE_0000 + 32'(k), 4'hF, m_rd, m_er);
      check("skew_aw_count", 64'(aw_hs - aw0), 64'd1);
      check("skew_w_count", 64'(w_hs - w0), 64'd1);
      check("skew_err", 64'(er), 64'd0);
    end
    aw_delay = 0; w_delay = 0;

    // Response back-pressure: held response stays put, nothing new starts.
    send_req(1'b0, 32'h8, 32'h0, 4'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hC;
    while (!rsp_valid) @(negedge clk);
    ar0 = ar_hs;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_rdata", 64'(rsp_rdata), 64'd3);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    check("hold_no_new_ar", 64'(ar_hs - ar0), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    get_rsp(0, rd, er);
    check("hold_next_rdata", 64'(rd), 64'd4);

    // Reset while ARVALID waits on a slow slave.
    ar_delay = 5;
    send_req(1'b0, 32'h4, 32'h0, 4'h0);
    check("pre_reset_arvalid", 64'(arvalid), 64'd1);
    areset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    check("midreset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    areset = 1'b0; ar_delay = 0;
    @(negedge clk);
    check("postreset_ready", 64'(req_ready), 64'd1);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er);
    check("postreset_read", 64'(rd), 64'd2);

    // Randomized traffic against the model.
    for (int t = 0; t < 80; t++) begin
      logic        we;
      logic [31:0] addr, wd;
      logic [3:0]  ws;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      else
        addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      do_req(we, addr, wd, ws, $urandom_range(0, 2), rd, er);
      model_apply(we, addr, wd, ws, m_rd, m_er);
      check($sformatf("rand%0d_rdata", t), 64'(rd), 64'(m_rd));
      check($sformatf("rand%0d_err", t), 64'(er), 64'(m_er));
    end

    check("protocol_monitor", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
